// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and elaboration-time timing helpers
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Width needed to hold 0..v-1; never narrower than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int bit_cyc(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int tap_lo(input int bc, input int m_taps);
        return bc / 2 - m_taps / 2;
    endfunction

    function automatic int tap_hi(input int bc, input int m_taps);
        return bc / 2 + m_taps / 2;
    endfunction

    function automatic int decide_at(input int bc, input int m_taps);
        return bc / 2 + m_taps / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_majority.sv
// rtl/uart_majority.sv - tap shift register and majority vote over the bit centre
module uart_majority #(
    parameter int M_TAPS  = 3,
    parameter int BIT_CYC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic vote
);

    generate
        if (M_TAPS < 1 || M_TAPS > 15 || (M_TAPS % 2) == 0) begin : g_bad_taps
            $error("uart_majority: M_TAPS must be odd and in 1..15");
        end
        if (M_TAPS > BIT_CYC / 2) begin : g_bad_window
            $error("uart_majority: M_TAPS must not exceed BIT_CYC/2");
        end
    endgenerate

    logic [M_TAPS-1:0] taps;

    // The window is exactly M_TAPS cycles long, so every bit refills all taps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            taps <= '0;
        end else if (en) begin
            taps <= M_TAPS'({taps, din});
        end
    end

    assign vote = ($countones(taps) > (M_TAPS / 2));

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: synchroniser, bit timer, voting, framing FSM
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9_600,
    parameter int PARITY    = 0,
    parameter int DO_WIDTH  = 8,
    parameter int M_TAPS    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [DO_WIDTH-1:0] dout,
    output logic                dout_vld,
    output logic                rx_err,
    output logic                rx_busy
);

    localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD_RATE);
    localparam int CW      = clog2(BIT_CYC);
    localparam int IW      = clog2(DO_WIDTH);

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] TAP_LO   = CW'(tap_lo(BIT_CYC, M_TAPS));
    localparam logic [CW-1:0] TAP_HI   = CW'(tap_hi(BIT_CYC, M_TAPS));
    localparam logic [CW-1:0] DECIDE   = CW'(decide_at(BIT_CYC, M_TAPS));
    localparam logic [IW-1:0] IDX_LAST = IW'(DO_WIDTH - 1);

    generate
        if (DO_WIDTH < 1 || DO_WIDTH > 16) begin : g_bad_width
            $error("uart_rx: DO_WIDTH must be in 1..16");
        end
        if (decide_at(BIT_CYC, M_TAPS) > BIT_CYC - 1) begin : g_bad_decide
            $error("uart_rx: decision point falls outside the bit period");
        end
    endgenerate

    rx_state_t           state;
    logic                rx_meta;
    logic                rxs;
    logic                rxs_d;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       bit_idx;
    logic [DO_WIDTH-1:0] shreg;
    logic                par_bit;
    logic                vote;
    logic                start_edge;
    logic                in_window;
    logic                decide;
    logic                bit_end;
    logic                frame_ok;

    assign start_edge = !rxs && rxs_d;
    assign in_window  = (state != RX_IDLE) && (cnt >= TAP_LO) && (cnt <= TAP_HI);
    assign decide     = (state != RX_IDLE) && (cnt == DECIDE);
    assign bit_end    = (cnt == CNT_LAST);
    // Evaluated in the STOP decision cycle, where vote is the stop bit.
    assign frame_ok   = vote && ((PARITY == 0) || !(^{shreg, par_bit}));

    uart_majority #(
        .M_TAPS (M_TAPS),
        .BIT_CYC(BIT_CYC)
    ) u_majority (
        .clk (clk),
        .rst (rst),
        .en  (in_window),
        .din (rxs),
        .vote(vote)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RX_IDLE;
            rx_meta  <= 1'b0;
            rxs      <= 1'b0;
            rxs_d    <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            rx_err   <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_d    <= rxs;
            dout_vld <= 1'b0;
            rx_err   <= 1'b0;

            if (state != RX_IDLE) begin
                cnt <= bit_end ? '0 : cnt + 1'b1;
            end

            case (state)
                RX_IDLE: begin
                    if (start_edge) begin
                        state   <= RX_START;
                        cnt     <= '0;
                        bit_idx <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                RX_START: begin
                    if (decide && vote) begin
                        state   <= RX_IDLE;
                        rx_busy <= 1'b0;
                    end else if (bit_end) begin
                        state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (decide) begin
                        shreg <= DO_WIDTH'({vote, shreg} >> 1);
                    end
                    if (bit_end) begin
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (decide) begin
                        par_bit <= vote;
                    end
                    if (bit_end) begin
                        state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Leave mid-stop so a following start edge is never missed.
                    if (decide) begin
                        state   <= RX_IDLE;
                        rx_busy <= 1'b0;
                        if (frame_ok) begin
                            dout     <= shreg;
                            dout_vld <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= RX_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx, no-parity and even-parity instances
module tb_uart_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int BC       = 10;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       vld0, vld1, err0, err1, busy0, busy1;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(0), .DO_WIDTH(8), .M_TAPS(3)
    ) dut0 (
        .clk(clk), .rst(rst), .rx(rx0),
        .dout(dout0), .dout_vld(vld0), .rx_err(err0), .rx_busy(busy0)
    );

    uart_rx #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(1), .DO_WIDTH(8), .M_TAPS(3)
    ) dut1 (
        .clk(clk), .rst(rst), .rx(rx1),
        .dout(dout1), .dout_vld(vld1), .rx_err(err1), .rx_busy(busy1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst && (vld0 || err0)) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected strobe {vld,err}", {14'd0, vld0, err0}, 16'd0);
            end else begin
                e = q0.pop_front();
                check("dut0 strobe {vld,err}", {14'd0, vld0, err0}, {14'd0, ~e.err, e.err});
                check("dut0 dout", {8'd0, dout0}, {8'd0, e.data});
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst && (vld1 || err1)) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected strobe {vld,err}", {14'd0, vld1, err1}, 16'd0);
            end else begin
                e = q1.pop_front();
                check("dut1 strobe {vld,err}", {14'd0, vld1, err1}, {14'd0, ~e.err, e.err});
                check("dut1 dout", {8'd0, dout1}, {8'd0, e.data});
            end
        end
    end

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic idle(input int which, input int n);
        drive(which, 1'b1);
        repeat (n) @(negedge clk);
    endtask

    // One frame; the single cycle (gbit, gcyc) of the line is inverted when gbit >= 0.
    task automatic send(input int which, input logic [7:0] data, input logic par_en,
                        input logic par, input logic stop, input int gbit, input int gcyc);
        logic [10:0] bits;
        int          n;
        logic        v;
        bits      = '0;
        bits[8:1] = data;
        if (par_en) begin
            bits[9]  = par;
            bits[10] = stop;
            n        = 11;
        end else begin
            bits[9] = stop;
            n       = 10;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < BC; c++) begin
                v = bits[b];
                if (b == gbit && c == gcyc) v = ~v;
                drive(which, v);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [8:0] partial;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dout0", {8'd0, dout0}, 16'd0);
        check("reset strobes0", {14'd0, vld0, err0}, 16'd0);
        check("reset busy0", {15'd0, busy0}, 16'd0);
        check("reset dout1", {8'd0, dout1}, 16'd0);
        check("reset strobes1", {14'd0, vld1, err1}, 16'd0);
        check("reset busy1", {15'd0, busy1}, 16'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: plain 8N1 frame
        q0.push_back('{err: 1'b0, data: 8'h64});
        send(0, 8'h64, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(0, 3);
        check("t1 busy after frame", {15'd0, busy0}, 16'd0);

        // 2: even parity good, then bad parity keeps last word
        q1.push_back('{err: 1'b0, data: 8'hA5});
        send(1, 8'hA5, 1'b1, 1'b0, 1'b1, -1, -1);
        idle(1, 3);
        q1.push_back('{err: 1'b1, data: 8'hA5});
        send(1, 8'hA5, 1'b1, 1'b1, 1'b1, -1, -1);
        idle(1, 3);
        check("t2 dout1 held", {8'd0, dout1}, 16'h00A5);
        check("t2 busy1", {15'd0, busy1}, 16'd0);

        // 3: framing error, one idle bit, then a good frame
        q0.push_back('{err: 1'b1, data: 8'h64});
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(0, BC);
        q0.push_back('{err: 1'b0, data: 8'h0F});
        send(0, 8'h0F, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(0, 3);

        // 4: 3-cycle low pulse is a false start
        drive(0, 1'b0);
        repeat (3) @(negedge clk);
        drive(0, 1'b1);
        repeat (2) @(negedge clk);
        check("t4 busy during start", {15'd0, busy0}, 16'd1);
        repeat (12) @(negedge clk);
        check("t4 busy after false start", {15'd0, busy0}, 16'd0);
        q0.push_back('{err: 1'b0, data: 8'h81});
        send(0, 8'h81, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(0, 3);

        // 5: one-cycle inversion at the centre of data bit 3
        q0.push_back('{err: 1'b0, data: 8'h55});
        send(0, 8'h55, 1'b0, 1'b0, 1'b1, 4, 5);
        idle(0, 3);

        // 6: reset during data bit 4, then back-to-back frames
        partial = {8'hC3, 1'b0};
        for (int b = 0; b < 6; b++) begin
            for (int c = 0; c < ((b == 5) ? 5 : BC); c++) begin
                drive(0, partial[b]);
                @(negedge clk);
            end
        end
        rst = 1'b0;
        drive(0, 1'b1);
        repeat (3) @(negedge clk);
        check("t6 dout0 cleared by reset", {8'd0, dout0}, 16'd0);
        check("t6 busy0 cleared by reset", {15'd0, busy0}, 16'd0);
        rst = 1'b1;
        idle(0, 5);
        q0.push_back('{err: 1'b0, data: 8'h00});
        q0.push_back('{err: 1'b0, data: 8'hFF});
        send(0, 8'h00, 1'b0, 1'b0, 1'b1, -1, -1);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(0, 5);
        check("t6 final dout0", {8'd0, dout0}, 16'h00FF);

        check("dut0 missing strobes", 16'(q0.size()), 16'd0);
        check("dut1 missing strobes", 16'(q1.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
